// File: rtl/riscat_mem_pkg.sv
// Shared types and helpers for the data-memory responder and the lane aligner.
package riscat_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  // Byte-lane write mask; misaligned halves/words are force-aligned here.
  function automatic logic [3:0] byte_enables(mem_size_e size, logic [1:0] addr);
    case (size)
      MEM_BYTE: return 4'b0001 << addr;
      MEM_HALF: return addr[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: replicates store data onto every lane it could
// land in, and extracts/extends load data from a 32-bit RAM word.
module mem_lane_align
  import riscat_mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  addr,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  logic [31:0]        shifted;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  // Store replication and load extract with sign/zero extension.
  always_comb begin
    wlanes  = wdata;
    rdata   = rword;
    shifted = rword;
    ld_byte = '0;
    ld_half = '0;
    case (size)
      MEM_BYTE: begin
        wlanes  = {4{wdata[7:0]}};
        shifted = rword >> {addr, 3'b000};
        ld_byte = signed'(shifted[7:0]);
        rdata   = unsigned_ld ? {24'd0, shifted[7:0]} : 32'(ld_byte);
      end
      MEM_HALF: begin
        wlanes  = {2{wdata[15:0]}};
        shifted = rword >> {addr[1], 4'b0000};
        ld_half = signed'(shifted[15:0]);
        rdata   = unsigned_ld ? {16'd0, shifted[15:0]} : 32'(ld_half);
      end
      default: begin
        wlanes = wdata;
        rdata  = rword;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with a word-organised RAM and a
// programmable response latency. Optional macro MEM_MISALIGN_CHECK_EN turns
// misaligned half/word accesses into errors instead of force-aligning them.
module mem_responder
  import riscat_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_BITS - 2);

  logic [31:0]          ram [DEPTH];
  mem_state_e           state;
  logic [3:0]           wait_cnt;
  mem_size_e            size;
  logic [ADDR_BITS-3:0] word_idx;
  logic                 out_of_range;
  logic                 misalign;
  logic                 req_err;
  logic                 accept;
  logic [3:0]           be;
  logic [31:0]          wlanes;
  logic [31:0]          ld_data;

  assign size         = mem_size_e'(req_size);
  assign word_idx     = req_addr[ADDR_BITS-1:2];
  assign out_of_range = |req_addr[31:ADDR_BITS];
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign     = ((size == MEM_HALF) && req_addr[0]) ||
                        ((size == MEM_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign     = 1'b0;
`endif
  assign req_err      = out_of_range || (size == MEM_RSVD) || misalign;
  assign accept       = (state == IDLE) && req_valid && !reset;
  assign be           = byte_enables(size, req_addr[1:0]);

  mem_lane_align u_align (
    .size        (size),
    .addr        (req_addr[1:0]),
    .unsigned_ld (req_unsigned),
    .wdata       (req_wdata),
    .rword       (ram[word_idx]),
    .wlanes      (wlanes),
    .rdata       (ld_data)
  );

  // Store commit on the accept edge; RAM is never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Handshake FSM; response fields are captured at accept and held until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_err   <= req_err;
            rsp_rdata <= (req_err || req_we) ? 32'd0 : ld_data;
            wait_cnt  <= '0;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-array model.
module tb_mem_responder;

  localparam int AB = 16;
  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_m [0:(1<<AB)-1];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-level reference: returns expected rdata/err and applies stores.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] a;
    logic [31:0] v;
    err = 1'b0;
    rd  = 32'd0;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a   = addr;
    if (addr >= (32'd1 << AB) || size == 2'd3) err = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
    if ((addr % n) != 0) err = 1'b1;
`endif
    a = addr - (addr % n);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[a[AB-1:0] + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a[AB-1:0] + i];
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    int          k;
    model_access(we, addr, size, uns, wd, exp_d, exp_e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
    req_size = 2'($urandom); req_unsigned = $urandom_range(0, 1); req_wdata = $urandom;
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 40) begin
      check_eq("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk); k++;
    end
    check_eq("latency", 32'(k), 32'(WS));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_e));
    check_eq("rsp_rdata", rsp_rdata, exp_d);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, exp_d);
      check_eq("hold_err", 32'(rsp_err), 32'(exp_e));
      check_eq("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check_eq("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        we, uns;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          r;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;

    // Give the test region known contents.
    for (int i = 0; i < 512; i++) do_req(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom, 0);

    do_req(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h200, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h203, 2'd0, 1'b0, 32'hFFFF_FF80, 0);
    do_req(1'b0, 32'h203, 2'd0, 1'b0, 32'h0, 1);
    do_req(1'b0, 32'h203, 2'd0, 1'b1, 32'h0, 0);
    do_req(1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h300, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h302, 2'd1, 1'b0, 32'hABCD1234, 0);
    do_req(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h302, 2'd1, 1'b0, 32'h0, 5);
    do_req(1'b0, 32'h10001, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b1, 32'h102, 2'd2, 1'b0, 32'h11223344, 2);
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 0);

    // Reset while a store sits in the wait phase.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'hA5A5A5A5;
    model_access(1'b1, 32'h40, 2'd2, 1'b0, 32'hA5A5A5A5, wd, we);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    r = 0;
    for (int i = 0; i < WS + 4; i++) begin
      if (rsp_valid) r++;
      @(negedge clk);
    end
    check_eq("midrst_no_rsp", 32'(r), 32'd0);
    do_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 7);
      sz  = (r == 7) ? 2'd3 : 2'(r % 3);
      a   = $urandom_range(0, 32'h7FF);
      if ($urandom_range(0, 9) == 0) a = 32'h10000 + $urandom_range(0, 32'hFFFF);
      wd  = $urandom;
      do_req(we, a, sz, uns, wd, $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
